// File: rtl/uart_dbg_bridge.sv
// UART debug bridge: byte-framed read/write commands from a UART receiver
// become single bus accesses; responses go back out through the UART transmitter.
module uart_dbg_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter logic [7:0]  CMD_WRITE      = 8'h57,
  parameter logic [7:0]  CMD_READ       = 8'h52,
  parameter logic [7:0]  ACK_BYTE       = 8'h4B,
  parameter logic [7:0]  NAK_BYTE       = 8'h3F
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        tx_busy,
  output logic        tx_en,
  output logic [7:0]  tx_data,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_DATA, S_ACCESS, S_RESP, S_GUARD
  } state_t;

  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic        op_wr_q, op_wr_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [31:0] to_cnt_q, to_cnt_d;
  logic [31:0] resp_q, resp_d;
  logic [2:0]  resp_len_q, resp_len_d;
  logic        tx_en_q, tx_en_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        mem_we_q, mem_we_d;
  logic        mem_re_q, mem_re_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;
  logic        to_hit;

  // Next-state and registered-output logic for the frame FSM.
  always_comb begin
    state_d     = state_q;
    op_wr_d     = op_wr_q;
    byte_cnt_d  = byte_cnt_q;
    to_cnt_d    = '0;
    resp_d      = resp_q;
    resp_len_d  = resp_len_q;
    tx_en_d     = 1'b0;
    tx_data_d   = tx_data_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    mem_re_d    = 1'b0;
    err_d       = 1'b0;
    to_hit      = (TIMEOUT_CYCLES != 0) && (to_cnt_q == TO_LAST) && !rx_valid;

    unique case (state_q)
      S_IDLE: begin
        if (rx_valid) begin
          if (rx_data == CMD_WRITE || rx_data == CMD_READ) begin
            op_wr_d    = (rx_data == CMD_WRITE);
            byte_cnt_d = '0;
            state_d    = S_ADDR;
          end else begin
            resp_d     = {NAK_BYTE, 24'h0};
            resp_len_d = 3'd1;
            state_d    = S_RESP;
          end
        end
      end
      S_ADDR: begin
        to_cnt_d = rx_valid ? '0 : to_cnt_q + 32'd1;
        if (rx_valid) begin
          mem_addr_d = {mem_addr_q[23:0], rx_data};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            to_cnt_d = '0;
            if (op_wr_q) begin
              state_d = S_DATA;
            end else begin
              state_d  = S_ACCESS;
              mem_re_d = 1'b1;
            end
          end
        end else if (to_hit) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end
      end
      S_DATA: begin
        to_cnt_d = rx_valid ? '0 : to_cnt_q + 32'd1;
        if (rx_valid) begin
          mem_wdata_d = {mem_wdata_q[23:0], rx_data};
          byte_cnt_d  = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            to_cnt_d = '0;
            state_d  = S_ACCESS;
            mem_we_d = 1'b1;
          end
        end else if (to_hit) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end
      end
      S_ACCESS: begin
        if (op_wr_q) begin
          resp_d     = {ACK_BYTE, 24'h0};
          resp_len_d = 3'd1;
        end else begin
          resp_d     = mem_rdata;
          resp_len_d = 3'd4;
        end
        state_d = S_RESP;
      end
      S_RESP: begin
        if (!tx_busy) begin
          tx_en_d    = 1'b1;
          tx_data_d  = resp_q[31:24];
          resp_d     = {resp_q[23:0], 8'h0};
          resp_len_d = resp_len_q - 3'd1;
          state_d    = S_GUARD;
        end
      end
      S_GUARD: begin
        state_d = (resp_len_q != 3'd0) ? S_RESP : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (rx_valid &&
        (state_q == S_ACCESS || state_q == S_RESP || state_q == S_GUARD))
      err_d = 1'b1;

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_wr_q     <= 1'b0;
      byte_cnt_q  <= '0;
      to_cnt_q    <= '0;
      resp_q      <= '0;
      resp_len_q  <= '0;
      tx_en_q     <= 1'b0;
      tx_data_q   <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_wr_q     <= op_wr_d;
      byte_cnt_q  <= byte_cnt_d;
      to_cnt_q    <= to_cnt_d;
      resp_q      <= resp_d;
      resp_len_q  <= resp_len_d;
      tx_en_q     <= tx_en_d;
      tx_data_q   <= tx_data_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      mem_re_q    <= mem_re_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  assign tx_en     = tx_en_q;
  assign tx_data   = tx_data_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign mem_re    = mem_re_q;
  assign busy      = busy_q;
  assign err       = err_q;

endmodule
